// File: rtl/gf_pe_multilane_if.sv
// Beat-level bundle between chained GF processing elements: input beat with valid/ready, registered output beat.
interface gf_pe_multilane_if #(
  parameter int GF_BIT = 4,
  parameter int LANES  = 4,
  parameter int ROW_W  = 8
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                op_in;
  logic                      start_in;
  logic                      finish_in;
  logic [GF_BIT-1:0]         key_data;
  logic [LANES*GF_BIT-1:0]   data_in;
  logic [LANES*GF_BIT-1:0]   dataA_in;
  logic [LANES*GF_BIT-1:0]   factor_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [2:0]                op_out;
  logic                      start_out;
  logic                      finish_out;
  logic [LANES*GF_BIT-1:0]   data_out;
  logic [LANES*GF_BIT-1:0]   factor_out;
  logic [LANES*2-1:0]        gauss_op_out;
  logic [LANES*ROW_W-1:0]    pivot_idx;
  logic [LANES-1:0]          singular;

  modport master (
    output in_valid, op_in, start_in, finish_in, key_data, data_in, dataA_in, factor_in, out_ready,
    input  in_ready, out_valid, op_out, start_out, finish_out, data_out, factor_out,
           gauss_op_out, pivot_idx, singular
  );

  modport slave (
    input  in_valid, op_in, start_in, finish_in, key_data, data_in, dataA_in, factor_in, out_ready,
    output in_ready, out_valid, op_out, start_out, finish_out, data_out, factor_out,
           gauss_op_out, pivot_idx, singular
  );
endinterface

// File: rtl/gf_pe_multilane.sv
// Multi-lane GF(2^4)/GF(2^8) systolic PE (accumulate, pivot search, elimination); latency 1, or 2 with PE_MUL_PIPE_EN.
// Stalls the whole cell while out_valid && !out_ready; state only changes on an accepted beat.
module gf_pe_multilane #(
  parameter int GF_BIT = 4,
  parameter int LANES  = 4,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  gf_pe_multilane_if.slave  pe
);
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_MAC   = 3'd3;
  localparam logic [2:0] OP_PIVOT = 3'd4;
  localparam logic [2:0] OP_ELIM  = 3'd5;

  localparam logic [1:0] G_SKIP  = 2'b00;
  localparam logic [1:0] G_NORM  = 2'b01;
  localparam logic [1:0] G_ELIM  = 2'b10;
  localparam logic [1:0] G_START = 2'b11;

  // x^4+x+1 for GF(16), AES x^8+x^4+x^3+x+1 for GF(256); only the low bits feed the reduction
  localparam int                POLY = (GF_BIT == 8) ? 'h11B : 'h13;
  localparam logic [GF_BIT-1:0] RED  = GF_BIT'(POLY);

  typedef logic [LANES-1:0][GF_BIT-1:0] lane_vec_t;
  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} pstate_t;

  typedef struct packed {
    logic [2:0]                   op;
    logic                         start;
    logic                         finish;
    lane_vec_t                    data;
    lane_vec_t                    factor;
    logic [LANES-1:0][1:0]        gauss;
    logic [LANES-1:0][ROW_W-1:0]  pivot;
    logic [LANES-1:0]             sing;
  } beat_t;

  function automatic logic [GF_BIT-1:0] gf_mul(input logic [GF_BIT-1:0] a, input logic [GF_BIT-1:0] b);
    logic [GF_BIT-1:0] p;
    logic [GF_BIT-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < GF_BIT; i++) begin
      if (b[i]) p = p ^ t;
      t = t[GF_BIT-1] ? ((t << 1) ^ RED) : (t << 1);
    end
    return p;
  endfunction

  // a^(2^n-2) as the product of a^2, a^4, ..., a^(2^(n-1)); maps 0 to 0
  function automatic logic [GF_BIT-1:0] gf_inv(input logic [GF_BIT-1:0] a);
    logic [GF_BIT-1:0] p;
    logic [GF_BIT-1:0] r;
    p = a;
    r = GF_BIT'(1);
    for (int k = 1; k < GF_BIT; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  lane_vec_t                    x, a, f;
  lane_vec_t                    r_q, r_d;
  pstate_t                      st_q [LANES];
  pstate_t                      st_d [LANES];
  logic [LANES-1:0][ROW_W-1:0]  piv_q, piv_d;
  logic [LANES-1:0]             sing_q, sing_d;
  logic [ROW_W-1:0]             cnt_q, beat_idx;
  logic                         rdy, accept, out_vld;
  beat_t                        o, out_q;

  assign x = pe.data_in;
  assign a = pe.dataA_in;
  assign f = pe.factor_in;

  assign rdy         = !out_vld || pe.out_ready;
  assign accept      = pe.in_valid && rdy;
  assign pe.in_ready = rdy;

  assign beat_idx = pe.start_in ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      r_q    <= '0;
      piv_q  <= '0;
      sing_q <= '0;
      for (int l = 0; l < LANES; l++) st_q[l] <= SEARCH;
    end else if (accept) begin
      cnt_q  <= beat_idx;
      r_q    <= r_d;
      piv_q  <= piv_d;
      sing_q <= sing_d;
      for (int l = 0; l < LANES; l++) st_q[l] <= st_d[l];
    end
  end

  always_comb begin
    r_d    = r_q;
    piv_d  = piv_q;
    sing_d = sing_q;
    for (int l = 0; l < LANES; l++) begin
      st_d[l] = st_q[l];
      case (pe.op_in)
        OP_LOAD:  r_d[l] = x[l];
        OP_CLEAR: r_d[l] = '0;
        OP_MAC:   r_d[l] = (pe.start_in ? '0 : r_q[l]) ^ gf_mul(pe.key_data, a[l]);
        OP_PIVOT: begin
          if (pe.start_in) begin
            st_d[l]   = SEARCH;
            r_d[l]    = '0;
            sing_d[l] = 1'b0;
          end
          if (st_d[l] == SEARCH && x[l] != '0) begin
            r_d[l]   = GF_BIT'(1);
            piv_d[l] = beat_idx;
            st_d[l]  = LOCKED;
          end
          if (pe.finish_in && st_d[l] == SEARCH) sing_d[l] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o        = '0;
    o.op     = pe.op_in;
    o.start  = pe.start_in;
    o.finish = pe.finish_in;
    o.pivot  = piv_d;
    o.sing   = sing_d;
    for (int l = 0; l < LANES; l++) begin
      o.data[l]   = x[l];
      o.factor[l] = '0;
      o.gauss[l]  = G_SKIP;
      case (pe.op_in)
        OP_LOAD:  o.data[l] = r_q[l];
        OP_CLEAR: o.data[l] = '0;
        OP_ELIM: begin
          o.data[l]   = x[l] ^ gf_mul(f[l], r_q[l]);
          o.factor[l] = f[l];
        end
        OP_PIVOT: begin
          if (pe.start_in || st_q[l] == SEARCH) begin
            if (x[l] != '0) begin
              o.factor[l] = gf_inv(x[l]);
              o.gauss[l]  = G_NORM;
            end
          end else if (x[l] != '0) begin
            o.factor[l] = x[l];
            o.gauss[l]  = G_ELIM;
          end
          if (pe.start_in) begin
            o.gauss[l] = G_START;
            o.data[l]  = '0;
          end
          if (pe.finish_in) o.data[l] = r_d[l];
        end
        default: ;
      endcase
    end
  end

`ifdef PE_MUL_PIPE_EN
  // State resolves in the first stage, so back-to-back MAC/PIVOT beats see the updated r directly
  beat_t stg_q;
  logic  stg_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q   <= '0;
      stg_vld <= 1'b0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (rdy) begin
      stg_vld <= accept;
      if (accept) stg_q <= o;
      out_vld <= stg_vld;
      if (stg_vld) out_q <= stg_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else if (rdy) begin
      out_vld <= pe.in_valid;
      if (accept) out_q <= o;
    end
  end
`endif

  assign pe.out_valid    = out_vld;
  assign pe.op_out       = out_q.op;
  assign pe.start_out    = out_q.start;
  assign pe.finish_out   = out_q.finish;
  assign pe.data_out     = out_q.data;
  assign pe.factor_out   = out_q.factor;
  assign pe.gauss_op_out = out_q.gauss;
  assign pe.pivot_idx    = out_q.pivot;
  assign pe.singular     = out_q.sing;
endmodule

// File: tb/tb_gf_pe_multilane.sv
// Directed bench for gf_pe_multilane in GF(16) (x^4+x+1), 4 lanes; expected values worked out by hand.
module tb_gf_pe_multilane;
  localparam int GF_BIT = 4;
  localparam int LANES  = 4;
  localparam int ROW_W  = 8;
`ifdef PE_MUL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2:0] PASS  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] MAC   = 3'd3;
  localparam logic [2:0] PIVOT = 3'd4;
  localparam logic [2:0] ELIM  = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  logic [15:0] s_data, s_factor;
  logic [7:0]  s_gauss;
  logic [31:0] s_piv;
  logic [3:0]  s_sing;
  logic [4:0]  s_ctl;
  logic [15:0] v;

  gf_pe_multilane_if #(.GF_BIT(GF_BIT), .LANES(LANES), .ROW_W(ROW_W)) pe_if ();

  gf_pe_multilane #(.GF_BIT(GF_BIT), .LANES(LANES), .ROW_W(ROW_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pe    (pe_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one beat, wait for acceptance, then wait for its output beat and snapshot it.
  task automatic do_beat(input logic [2:0] op, input logic st, input logic fin, input logic [3:0] key,
                         input logic [15:0] d, input logic [15:0] da, input logic [15:0] fa);
    int n;
    int lat;
    @(negedge clk);
    pe_if.op_in     = op;
    pe_if.start_in  = st;
    pe_if.finish_in = fin;
    pe_if.key_data  = key;
    pe_if.data_in   = d;
    pe_if.dataA_in  = da;
    pe_if.factor_in = fa;
    pe_if.in_valid  = 1'b1;
    n = 0;
    while (!pe_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    pe_if.in_valid = 1'b0;
    lat = 1;
    while (!pe_if.out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, LAT);
    s_data   = pe_if.data_out;
    s_factor = pe_if.factor_out;
    s_gauss  = pe_if.gauss_op_out;
    s_piv    = pe_if.pivot_idx;
    s_sing   = pe_if.singular;
    s_ctl    = {pe_if.op_out, pe_if.start_out, pe_if.finish_out};
  endtask

  initial begin
    pe_if.in_valid  = 1'b0;
    pe_if.op_in     = PASS;
    pe_if.start_in  = 1'b0;
    pe_if.finish_in = 1'b0;
    pe_if.key_data  = '0;
    pe_if.data_in   = '0;
    pe_if.dataA_in  = '0;
    pe_if.factor_in = '0;
    pe_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", pe_if.out_valid, 0);
    check("rst_in_ready", pe_if.in_ready, 1);
    check("rst_data", pe_if.data_out, 0);
    check("rst_pivot", pe_if.pivot_idx, 0);
    check("rst_singular", pe_if.singular, 0);
    rst_n = 1'b1;

    // Sweep A: lane0 0,0,3,5  lane1 all 0  lane2 0,4,0,0  lane3 0,0,0,9
    do_beat(PIVOT, 1, 0, 0, 16'h0000, 0, 0);
    check("A0_gauss", s_gauss, 8'hFF);
    check("A0_data", s_data, 16'h0000);
    do_beat(PIVOT, 0, 0, 0, 16'h0400, 0, 0);
    check("A1_gauss", s_gauss, 8'h10);
    check("A1_factor", s_factor, 16'h0D00);
    do_beat(PIVOT, 0, 0, 0, 16'h0003, 0, 0);
    check("A2_gauss", s_gauss, 8'h01);
    check("A2_factor_inv3", s_factor, 16'h000E);
    check("A2_data", s_data, 16'h0003);
    do_beat(PIVOT, 0, 1, 0, 16'h9005, 0, 0);
    check("A3_gauss", s_gauss, 8'h42);
    check("A3_factor", s_factor, 16'h2005);
    check("A3_data", s_data, 16'h1101);
    check("A3_pivot", s_piv, 32'h03010002);
    check("A3_singular", s_sing, 4'b0010);
    check("A3_ctl", s_ctl, 5'h11);

    // Single-beat sweep: start and finish together
    do_beat(PIVOT, 1, 1, 0, 16'h0070, 0, 0);
    check("S_gauss", s_gauss, 8'hFF);
    check("S_factor", s_factor, 16'h0060);
    check("S_data", s_data, 16'h0010);
    check("S_singular", s_sing, 4'b1101);

    // Sweep B with a 3-cycle output stall after beat 1
    do_beat(PIVOT, 1, 0, 0, 16'h0000, 0, 0);
    do_beat(PIVOT, 0, 0, 0, 16'h0080, 0, 0);
    check("B1_data", s_data, 16'h0080);
    check("B1_gauss", s_gauss, 8'h04);
    pe_if.out_ready = 1'b0;
    pe_if.op_in     = PIVOT;
    pe_if.start_in  = 1'b0;
    pe_if.finish_in = 1'b0;
    pe_if.data_in   = 16'h0000;
    pe_if.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", pe_if.in_ready, 0);
      check("stall_out_valid", pe_if.out_valid, 1);
      check("stall_data", pe_if.data_out, 16'h0080);
      check("stall_gauss", pe_if.gauss_op_out, 8'h04);
    end
    pe_if.in_valid  = 1'b0;
    pe_if.out_ready = 1'b1;
    do_beat(PIVOT, 0, 0, 0, 16'h0000, 0, 0);
    check("B2_gauss", s_gauss, 8'h00);
    do_beat(PIVOT, 0, 1, 0, 16'h0006, 0, 0);
    check("B3_gauss", s_gauss, 8'h01);
    check("B3_factor_inv6", s_factor, 16'h0007);
    check("B3_data", s_data, 16'h0011);
    check("B3_pivot", s_piv, 32'h03010103);
    check("B3_singular", s_sing, 4'b1100);

    // Counter saturation: many PASS beats, then a late pivot on lane2
    v = '0;
    for (int i = 0; i < 260; i++) begin
      v = 16'(i * 37 + 5);
      do_beat(PASS, 0, 0, 0, v, 0, 0);
    end
    check("pass_data", s_data, v);
    check("pass_gauss", s_gauss, 8'h00);
    do_beat(PIVOT, 0, 0, 0, 16'h0100, 0, 0);
    check("sat_pivot", s_piv, 32'h03FF0103);
    check("sat_gauss", s_gauss, 8'h10);
    check("sat_factor", s_factor, 16'h0100);

    // MAC accumulation with start dropping the preloaded r
    do_beat(LOAD, 0, 0, 0, 16'hFFFF, 0, 0);
    do_beat(MAC, 1, 0, 4'h2, 16'h1234, 16'h0151, 0);
    check("mac_pass_data", s_data, 16'h1234);
    do_beat(MAC, 0, 0, 4'h2, 16'h0000, 16'h0172, 0);
    do_beat(MAC, 0, 0, 4'h2, 16'h0000, 16'h0193, 0);
    do_beat(LOAD, 0, 0, 0, 16'h0000, 0, 0);
    check("mac_result", s_data, 16'h0250);

    // ELIM against loaded r, then CLEAR
    do_beat(LOAD, 0, 0, 0, 16'h7003, 0, 0);
    do_beat(ELIM, 0, 0, 0, 16'h1005, 0, 16'h6002);
    check("elim_data", s_data, 16'h0003);
    check("elim_factor", s_factor, 16'h6002);
    check("elim_ctl", s_ctl, 5'h14);
    do_beat(CLEAR, 0, 0, 0, 16'hABCD, 0, 0);
    check("clear_data", s_data, 16'h0000);
    do_beat(LOAD, 0, 0, 0, 16'h0000, 0, 0);
    check("load_after_clear", s_data, 16'h0000);
    check("pre_rst_singular", s_sing, 4'b1100);

    // Asynchronous reset while an output beat is valid
    check("pre_rst_out_valid", pe_if.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", pe_if.out_valid, 0);
    check("arst_singular", pe_if.singular, 0);
    check("arst_pivot", pe_if.pivot_idx, 0);
    check("arst_gauss", pe_if.gauss_op_out, 0);
    check("arst_factor", pe_if.factor_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
